rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, a rotating priority
// pointer, back-to-back re-arbitration on release, and an optional tenure
// watchdog that revokes a grant held for MAX_HOLD cycles.
module rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int IDX_WIDTH = $clog2(NREQ),
    parameter int MAX_HOLD  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic                 i_done,
    output logic [NREQ-1:0]      o_gnt,
    output logic [IDX_WIDTH-1:0] o_gnt_idx,
    output logic                 o_busy,
    output logic                 o_timeout
);

    // Tenure counter runs 0..MAX_HOLD-1; the last value is the expiry point.
    localparam int CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NREQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic                 win_found;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [IDX_WIDTH:0]   cand;
    logic                 expire;
    logic                 take;

    // Winner search: first asserted request at or above ptr, wrapping at NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = {1'b0, ptr_q} + (IDX_WIDTH+1)'(off);
            if (cand >= (IDX_WIDTH+1)'(NREQ)) begin
                cand = cand - (IDX_WIDTH+1)'(NREQ);
            end
            if (!win_found && i_req[cand[IDX_WIDTH-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_WIDTH-1:0];
            end
        end
    end

    // Watchdog fires on the last permitted cycle of a tenure; never when disabled.
    always_comb begin
        expire = (MAX_HOLD > 0) && (cnt_q == CNT_W'(HOLD_LAST));
    end

    // Next-state logic: grant on request in IDLE, release/re-arbitrate on done or expiry.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        take      = 1'b0;
        case (state_q)
            IDLE: begin
                take = win_found;
            end
            BUSY: begin
                if (i_done || expire) begin
                    // done wins over a coincident expiry, so no pulse then
                    timeout_d = expire && !i_done;
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (MAX_HOLD > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        // Every new grant (including a re-grant) moves ptr past the winner
        // and restarts the tenure count.
        if (take) begin
            state_d = BUSY;
            gnt_d   = NREQ'(1) << win_idx;
            ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            cnt_d   = '0;
        end
    end

    // State register; reset overrides any grant, release or timeout in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs: busy from state, index by OR-mux of the one-hot grant.
    always_comb begin
        o_gnt     = gnt_q;
        o_timeout = timeout_q;
        o_busy    = (state_q == BUSY);
        o_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) begin
                o_gnt_idx = o_gnt_idx | IDX_WIDTH'(k);
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: a 4-requester instance with a 16-cycle watchdog and a
// 5-requester instance with the watchdog disabled, each compared cycle by
// cycle against a behavioural owner/pointer/tenure model.
module tb_rr_arbiter;

    logic       i_clk = 1'b0;

    logic       a_rst = 1'b1;
    logic [3:0] a_req = '0;
    logic       a_done = 1'b0;
    logic [3:0] a_gnt;
    logic [1:0] a_idx;
    logic       a_busy;
    logic       a_to;

    logic       b_rst = 1'b1;
    logic [4:0] b_req = '0;
    logic       b_done = 1'b0;
    logic [4:0] b_gnt;
    logic [2:0] b_idx;
    logic       b_busy;
    logic       b_to;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: owner index (-1 = idle), priority pointer, cycles held
    int   ma_own = -1, ma_ptr = 0, ma_ten = 0;
    logic ma_to = 1'b0;
    int   mb_own = -1, mb_ptr = 0, mb_ten = 0;
    logic mb_to = 1'b0;

    always #5 i_clk = ~i_clk;

    rr_arbiter #(.NREQ(4), .MAX_HOLD(16)) dut_a (
        .i_clk(i_clk), .i_rst(a_rst), .i_req(a_req), .i_done(a_done),
        .o_gnt(a_gnt), .o_gnt_idx(a_idx), .o_busy(a_busy), .o_timeout(a_to)
    );

    rr_arbiter #(.NREQ(5), .MAX_HOLD(0)) dut_b (
        .i_clk(i_clk), .i_rst(b_rst), .i_req(b_req), .i_done(b_done),
        .o_gnt(b_gnt), .o_gnt_idx(b_idx), .o_busy(b_busy), .o_timeout(b_to)
    );

    function automatic int pick(input int n, input logic [31:0] req, input int ptr);
        for (int off = 0; off < n; off++) begin
            int k;
            k = (ptr + off) % n;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic mstep(input int n, input int maxh, input logic [31:0] req,
                         input logic done, input logic rst,
                         inout int own, inout int ptr, inout int ten, inout logic to);
        int k;
        if (rst) begin
            own = -1; ptr = 0; ten = 0; to = 1'b0;
            return;
        end
        to = 1'b0;
        if (own < 0) begin
            k = pick(n, req, ptr);
            if (k >= 0) begin own = k; ptr = (k + 1) % n; ten = 0; end
        end else if (done || (maxh > 0 && ten + 1 >= maxh)) begin
            to = !done;
            k = pick(n, req, ptr);
            if (k >= 0) begin own = k; ptr = (k + 1) % n; ten = 0; end
            else begin own = -1; ten = 0; end
        end else begin
            ten++;
        end
    endtask

    function automatic logic [7:0] exp_a();
        logic [3:0] g;
        logic [1:0] ix;
        g  = (ma_own < 0) ? 4'b0 : 4'(1 << ma_own);
        ix = (ma_own < 0) ? 2'b0 : 2'(ma_own);
        return {g, ix, (ma_own >= 0), ma_to};
    endfunction

    function automatic logic [9:0] exp_b();
        logic [4:0] g;
        logic [2:0] ix;
        g  = (mb_own < 0) ? 5'b0 : 5'(1 << mb_own);
        ix = (mb_own < 0) ? 3'b0 : 3'(mb_own);
        return {g, ix, (mb_own >= 0), mb_to};
    endfunction

    // apply inputs, advance one edge, update model, settle at the falling edge
    task automatic drive_a(input logic [3:0] req, input logic done, input logic rst);
        a_req = req; a_done = done; a_rst = rst;
        @(posedge i_clk);
        mstep(4, 16, 32'(req), done, rst, ma_own, ma_ptr, ma_ten, ma_to);
        @(negedge i_clk);
    endtask

    task automatic drive_b(input logic [4:0] req, input logic done, input logic rst);
        b_req = req; b_done = done; b_rst = rst;
        @(posedge i_clk);
        mstep(5, 0, 32'(req), done, rst, mb_own, mb_ptr, mb_ten, mb_to);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        drive_a(4'b1111, 1'b1, 1'b1);
        drive_a(4'b1111, 1'b1, 1'b1);
        n_cmp++;
        if ({a_gnt, a_idx, a_busy, a_to} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset: got gnt=%b idx=%0d busy=%b to=%b, want all zero", a_gnt, a_idx, a_busy, a_to);
        end
        drive_a(4'b0000, 1'b0, 1'b0);
        n_cmp++;
        if ({a_gnt, a_busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got gnt=%b busy=%b, want 0000 0", a_gnt, a_busy);
        end
    endtask

    task automatic test_rotation();
        int seq[$];
        int want[5] = '{0, 1, 2, 3, 0};
        logic [3:0] prev;
        drive_a(4'b0000, 1'b0, 1'b1);
        drive_a(4'b1111, 1'b0, 1'b0);
        seq.push_back(int'(a_idx));
        prev = a_gnt;
        for (int i = 1; i <= 12; i++) begin
            drive_a(4'b1111, (i % 3 == 0), 1'b0);
            n_cmp++;
            if ({a_gnt, a_idx, a_busy, a_to} !== exp_a()) begin
                n_fail++;
                $display("FAIL rotation cyc %0d: got %b want %b", i, {a_gnt, a_idx, a_busy, a_to}, exp_a());
            end
            if (a_gnt !== prev) seq.push_back(int'(a_idx));
            prev = a_gnt;
        end
        n_cmp++;
        if (seq.size() != 5 || seq[0] != want[0] || seq[1] != want[1] || seq[2] != want[2]
            || seq[3] != want[3] || seq[4] != want[4]) begin
            n_fail++;
            $display("FAIL rotation_order: got %p want 0,1,2,3,0", seq);
        end
    endtask

    task automatic test_hold();
        drive_a(4'b0000, 1'b0, 1'b1);
        drive_a(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_a(4'b0000, 1'b0, 1'b0);
            n_cmp++;
            if ({a_gnt, a_busy} !== 5'b0100_1 || {a_gnt, a_idx, a_busy, a_to} !== exp_a()) begin
                n_fail++;
                $display("FAIL hold cyc %0d: got gnt=%b busy=%b want 0100 1", i, a_gnt, a_busy);
            end
        end
    endtask

    task automatic test_wrap();
        drive_a(4'b0000, 1'b0, 1'b1);
        drive_a(4'b1000, 1'b0, 1'b0);
        n_cmp++;
        if (a_gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_first: got %b want 1000", a_gnt);
        end
        drive_a(4'b1010, 1'b1, 1'b0);
        n_cmp++;
        if ({a_gnt, a_idx, a_busy} !== 7'b0010_01_1 || {a_gnt, a_idx, a_busy, a_to} !== exp_a()) begin
            n_fail++;
            $display("FAIL wrap_regrant: got gnt=%b idx=%0d busy=%b want 0010 1 1", a_gnt, a_idx, a_busy);
        end
    endtask

    task automatic test_timeout();
        int held0  = 0;
        int pulses = 0;
        drive_a(4'b0000, 1'b0, 1'b1);
        drive_a(4'b0011, 1'b0, 1'b0);
        if (a_gnt === 4'b0001) held0++;
        for (int i = 0; i < 20; i++) begin
            drive_a(4'b0011, 1'b0, 1'b0);
            n_cmp++;
            if ({a_gnt, a_idx, a_busy, a_to} !== exp_a()) begin
                n_fail++;
                $display("FAIL timeout cyc %0d: got %b want %b", i, {a_gnt, a_idx, a_busy, a_to}, exp_a());
            end
            if (a_gnt === 4'b0001) held0++;
            if (a_to === 1'b1) begin
                pulses++;
                n_cmp++;
                if (a_gnt !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL timeout_move: got %b want 0010", a_gnt);
                end
            end
        end
        n_cmp++;
        if (held0 != 16 || pulses != 1) begin
            n_fail++;
            $display("FAIL timeout_count: got held=%0d pulses=%0d want held=16 pulses=1", held0, pulses);
        end
    endtask

    task automatic test_done_vs_timeout_and_reset();
        drive_a(4'b0000, 1'b0, 1'b1);
        drive_a(4'b0011, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) drive_a(4'b0011, 1'b0, 1'b0);
        drive_a(4'b0011, 1'b1, 1'b0);
        n_cmp++;
        if ({a_gnt, a_to} !== 5'b0010_0 || {a_gnt, a_idx, a_busy, a_to} !== exp_a()) begin
            n_fail++;
            $display("FAIL done_beats_timeout: got gnt=%b to=%b want 0010 0", a_gnt, a_to);
        end
        drive_a(4'b1111, 1'b1, 1'b1);
        n_cmp++;
        if ({a_gnt, a_busy, a_to} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got gnt=%b busy=%b to=%b want 0000 0 0", a_gnt, a_busy, a_to);
        end
        drive_a(4'b1111, 1'b0, 1'b0);
        n_cmp++;
        if ({a_gnt, a_idx} !== 6'b0001_00) begin
            n_fail++;
            $display("FAIL post_reset_grant: got gnt=%b idx=%0d want 0001 0", a_gnt, a_idx);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_a(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
            n_cmp++;
            if ({a_gnt, a_idx, a_busy, a_to} !== exp_a()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, {a_gnt, a_idx, a_busy, a_to}, exp_a());
            end
        end
    endtask

    task automatic test_nreq5();
        drive_b(5'b00000, 1'b0, 1'b1);
        drive_b(5'b01000, 1'b0, 1'b0);
        drive_b(5'b10001, 1'b1, 1'b0);
        n_cmp++;
        if ({b_gnt, b_idx} !== 8'b10000_100 || {b_gnt, b_idx, b_busy, b_to} !== exp_b()) begin
            n_fail++;
            $display("FAIL n5_grant4: got gnt=%b idx=%0d want 10000 4", b_gnt, b_idx);
        end
        drive_b(5'b10001, 1'b1, 1'b0);
        n_cmp++;
        if ({b_gnt, b_idx} !== 8'b00001_000 || {b_gnt, b_idx, b_busy, b_to} !== exp_b()) begin
            n_fail++;
            $display("FAIL n5_wrap0: got gnt=%b idx=%0d want 00001 0", b_gnt, b_idx);
        end
        for (int i = 0; i < 40; i++) begin
            drive_b(5'b11111, 1'b0, 1'b0);
            n_cmp++;
            if ({b_gnt, b_to} !== 6'b00001_0 || {b_gnt, b_idx, b_busy, b_to} !== exp_b()) begin
                n_fail++;
                $display("FAIL n5_no_watchdog cyc %0d: got gnt=%b to=%b want 00001 0", i, b_gnt, b_to);
            end
        end
        for (int i = 0; i < 200; i++) begin
            drive_b(5'($urandom), ($urandom_range(0, 2) == 0), 1'b0);
            n_cmp++;
            if ({b_gnt, b_idx, b_busy, b_to} !== exp_b()) begin
                n_fail++;
                $display("FAIL n5_random cyc %0d: got %b want %b", i, {b_gnt, b_idx, b_busy, b_to}, exp_b());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_wrap();
        test_timeout();
        test_done_vs_timeout_and_reset();
        test_random();
        a_rst = 1'b1;
        test_nreq5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
